piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the parallel word width in bits (SIZE >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = MSB transmitted first, 0 = LSB first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 0, giving the shift_out level when no frame is active.
REQ-004 The block SHALL have a single clock domain and asynchronous active-high reset, with ports as listed below.
REQ-005 clk  input  1  rising-edge clock, the only clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 parallel_in  input  SIZE  word to serialize, sampled on load handshake.
REQ-008 load_valid  input  1  producer offers parallel_in.
REQ-009 load_ready  output  1  block accepts a word this cycle (combinational).
REQ-010 en  input  1  shift strobe; one bit consumed per clk with en=1 during a frame.
REQ-011 shift_in  input  1  fill bit entering the vacated register end on each shift.
REQ-012 shift_out  output  1  current serial bit.
REQ-013 frame  output  1  high while shift_out carries a valid data bit.
REQ-014 bit_cnt  output  $clog2(SIZE+1)  bits remaining in the current frame.
REQ-015 done  output  1  one-cycle pulse after the last bit of a frame is consumed.
REQ-016 parallel_out  output  SIZE  current shift register contents.

Function
REQ-017 The FSM SHALL have two states: IDLE and SHIFT.
REQ-018 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when bit_cnt==1 and en==1; otherwise 0.
REQ-019 A load occurs on a clk edge with load_valid && load_ready: shift_reg <= parallel_in, bit_cnt <= SIZE, state <= SHIFT.
REQ-020 In SHIFT with en=1 and no load: MSB_FIRST=1 -> shift_reg <= {shift_reg[SIZE-2:0], shift_in}; MSB_FIRST=0 -> shift_reg <= {shift_in, shift_reg[SIZE-1:1]}; bit_cnt decrements by 1.
REQ-021 In SHIFT with en=0, shift_reg, bit_cnt and state SHALL hold.
REQ-022 When bit_cnt==1 and en=1 with no load, state SHALL go to IDLE and bit_cnt to 0.
REQ-023 When bit_cnt==1, en=1 and load_valid=1, the new word SHALL load with no idle gap (back-to-back frames), and done SHALL still pulse.
REQ-024 done SHALL be registered, set for exactly one cycle following any edge on which the last bit (bit_cnt==1, en=1) is consumed.
REQ-025 frame SHALL equal (state==SHIFT).
REQ-026 shift_out SHALL be shift_reg[SIZE-1] (MSB_FIRST=1) or shift_reg[0] (MSB_FIRST=0) when frame=1, and IDLE_LEVEL when frame=0.
REQ-027 parallel_out SHALL equal shift_reg at all times, including in IDLE.
REQ-028 load_valid while load_ready=0 SHALL be ignored, with no state change.
REQ-029 en in IDLE SHALL have no effect on shift_reg or bit_cnt.
REQ-030 Bit latency SHALL be zero: the first bit appears on shift_out the cycle after the load edge.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, shift_reg=0, bit_cnt=0, done=0; hence frame=0, shift_out=IDLE_LEVEL, load_ready=1, parallel_out=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame without a done pulse; after release the block SHALL accept a new load on the first edge.

Verification
REQ-033 SIZE=4, MSB_FIRST=1: load 4'b1011, en=1 continuous -> shift_out 1,0,1,1 on 4 consecutive cycles, frame high 4 cycles, bit_cnt 4,3,2,1, done high on 5th cycle, shift_out=IDLE_LEVEL afterwards.
REQ-034 SIZE=4, MSB_FIRST=0: load 4'b1011 -> shift_out 1,1,0,1; with shift_in=1, parallel_out after the frame =4'b1111.
REQ-035 Back-to-back: load 4'hA, hold load_valid with 4'h5 -> 8 contiguous bits 1010_0101, frame never drops, done pulses twice.
REQ-036 en gaps: load 4'b1100, en pattern 1,0,0,1,1,0,1 -> each bit holds through en=0 cycles; bit_cnt holds; done after the 4th en.
REQ-037 load_valid asserted mid-frame (bit_cnt=3) with 4'hF -> ignored, load_ready=0, original word completes.
REQ-038 Reset at bit_cnt=2 -> immediate frame=0, bit_cnt=0, parallel_out=0, no done; load 4'h9 next edge after release -> normal frame.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a load handshake, en-gated shifting and
// back-to-back frame support (a new word can load on the last-bit edge).
module piso_serializer #(
  parameter int unsigned SIZE       = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE-1:0]             parallel_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic                        en,
  input  logic                        shift_in,
  output logic                        shift_out,
  output logic                        frame,
  output logic [$clog2(SIZE+1)-1:0]   bit_cnt,
  output logic                        done,
  output logic [SIZE-1:0]             parallel_out
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [SIZE-1:0] shift_reg;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic            last_bit;
  logic            load;
  logic [SIZE-1:0] shifted;

  // Last bit is consumed on this edge; the same edge may accept the next word.
  assign last_bit   = (state == SHIFT) && (cnt == CW'(1)) && en;
  assign load_ready = (state == IDLE) || last_bit;
  assign load       = load_valid && load_ready;

  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST) shifted = {shift_reg[SIZE-2:0], shift_in};
    else           shifted = {shift_in, shift_reg[SIZE-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (load) begin
        shift_reg <= parallel_in;
        cnt       <= CW'(SIZE);
        state     <= SHIFT;
      end else if ((state == SHIFT) && en) begin
        shift_reg <= shifted;
        cnt       <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= IDLE;
      end
    end
  end

  assign frame        = (state == SHIFT);
  assign bit_cnt      = cnt;
  assign done         = done_q;
  assign parallel_out = shift_reg;
  assign shift_out    = frame ? (MSB_FIRST ? shift_reg[SIZE-1] : shift_reg[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two SIZE=4 instances (MSB-first idle-low, LSB-first idle-high)
// share stimulus; expected serial bits and done cycles are queued and popped by monitors.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] parallel_in;
  logic       load_valid, en, shift_in;

  logic       load_ready_m, shift_out_m, frame_m, done_m;
  logic [2:0] bit_cnt_m;
  logic [3:0] parallel_out_m;
  logic       load_ready_l, shift_out_l, frame_l, done_l;
  logic [2:0] bit_cnt_l;
  logic [3:0] parallel_out_l;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  typedef struct packed {
    logic       b;
    logic [2:0] cnt;
  } exp_t;

  exp_t qm[$];
  exp_t ql[$];
  int   dm[$];
  int   dl[$];

  piso_serializer #(.SIZE(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready_m), .en(en), .shift_in(shift_in), .shift_out(shift_out_m),
    .frame(frame_m), .bit_cnt(bit_cnt_m), .done(done_m), .parallel_out(parallel_out_m)
  );

  piso_serializer #(.SIZE(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready_l), .en(en), .shift_in(shift_in), .shift_out(shift_out_l),
    .frame(frame_l), .bit_cnt(bit_cnt_l), .done(done_l), .parallel_out(parallel_out_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Monitors: pop one expectation per frame cycle and per done pulse.
  always @(negedge clk) begin : mon_m
    exp_t e;
    if (frame_m) begin
      if (qm.size() == 0) chk("m_unexpected_frame", 32'd1, 32'd0);
      else begin
        e = qm.pop_front();
        chk("m_shift_out", {31'd0, shift_out_m}, {31'd0, e.b});
        chk("m_bit_cnt", {29'd0, bit_cnt_m}, {29'd0, e.cnt});
      end
    end
    if (done_m) begin
      if (dm.size() == 0) chk("m_unexpected_done", 32'd1, 32'd0);
      else chk("m_done_cycle", cyc_n, dm.pop_front());
    end
  end

  always @(negedge clk) begin : mon_l
    exp_t e;
    if (frame_l) begin
      if (ql.size() == 0) chk("l_unexpected_frame", 32'd1, 32'd0);
      else begin
        e = ql.pop_front();
        chk("l_shift_out", {31'd0, shift_out_l}, {31'd0, e.b});
        chk("l_bit_cnt", {29'd0, bit_cnt_l}, {29'd0, e.cnt});
      end
    end
    if (done_l) begin
      if (dl.size() == 0) chk("l_unexpected_done", 32'd1, 32'd0);
      else chk("l_done_cycle", cyc_n, dl.pop_front());
    end
  end

  task automatic cyc(input logic lv, input logic [3:0] pin, input logic e, input logic si);
    @(posedge clk);
    #1;
    load_valid  = lv;
    parallel_in = pin;
    en          = e;
    shift_in    = si;
  endtask

  // One frame cycle showing bit k of word w (bits remaining = 4-k).
  task automatic fc(input logic [3:0] w, input int k, input logic lv, input logic [3:0] pin,
                    input logic e, input logic si, input bit last);
    cyc(lv, pin, e, si);
    qm.push_back('{b: w[3-k], cnt: 3'(4 - k)});
    ql.push_back('{b: w[k],   cnt: 3'(4 - k)});
    if (last) begin
      dm.push_back(cyc_n + 1);
      dl.push_back(cyc_n + 1);
    end
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clk);
    chk({tag, "_m_frame"}, {31'd0, frame_m}, 32'd0);
    chk({tag, "_l_frame"}, {31'd0, frame_l}, 32'd0);
    chk({tag, "_m_idle_level"}, {31'd0, shift_out_m}, 32'd0);
    chk({tag, "_l_idle_level"}, {31'd0, shift_out_l}, 32'd1);
    chk({tag, "_m_ready"}, {31'd0, load_ready_m}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wd;
    logic [6:0] en_pat;
    int k;
    reset = 1'b1; parallel_in = '0; load_valid = 1'b0; en = 1'b0; shift_in = 1'b0;

    // Reset state
    #2;
    chk("rst_m_frame", {31'd0, frame_m}, 32'd0);
    chk("rst_m_shift_out", {31'd0, shift_out_m}, 32'd0);
    chk("rst_l_shift_out", {31'd0, shift_out_l}, 32'd1);
    chk("rst_m_ready", {31'd0, load_ready_m}, 32'd1);
    chk("rst_m_pout", {28'd0, parallel_out_m}, 32'd0);
    chk("rst_m_cnt", {29'd0, bit_cnt_m}, 32'd0);
    chk("rst_m_done", {31'd0, done_m}, 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    reset = 1'b0;
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("idle_en_m_cnt", {29'd0, bit_cnt_m}, 32'd0);
    chk("idle_en_m_pout", {28'd0, parallel_out_m}, 32'd0);

    // Single frame 1011, shift_in=1 fills register to 1111
    wd = 4'b1011;
    cyc(1'b1, wd, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) fc(wd, i, 1'b0, 4'h0, 1'b1, 1'b1, i == 3);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    idle_checks("t1");
    chk("t1_m_pout", {28'd0, parallel_out_m}, 32'hF);
    chk("t1_l_pout", {28'd0, parallel_out_l}, 32'hF);

    // Back-to-back A then 5 with load_valid held
    cyc(1'b1, 4'hA, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fc(4'hA, i, 1'b1, 4'h5, 1'b1, 1'b0, i == 3);
      @(negedge clk);
      chk("t2_m_ready", {31'd0, load_ready_m}, (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) fc(4'h5, i, 1'b0, 4'h0, 1'b1, 1'b0, i == 3);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    idle_checks("t2");

    // en gaps: 1,0,0,1,1,0,1 (pattern read from bit 6 down)
    wd = 4'b1100;
    en_pat = 7'b1001101;
    cyc(1'b1, wd, 1'b0, 1'b0);
    k = 0;
    for (int i = 6; i >= 0; i--) begin
      fc(wd, k, 1'b0, 4'h0, en_pat[i], 1'b0, (k == 3) && en_pat[i]);
      if (en_pat[i]) k++;
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    idle_checks("t3");

    // load_valid with F at bit_cnt=3 is ignored
    wd = 4'b1011;
    cyc(1'b1, wd, 1'b1, 1'b0);
    fc(wd, 0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    fc(wd, 1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_m_ready", {31'd0, load_ready_m}, 32'd0);
    chk("t4_l_ready", {31'd0, load_ready_l}, 32'd0);
    fc(wd, 2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    fc(wd, 3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    idle_checks("t4");

    // Reset at bit_cnt=2 aborts without done, then load 9 right after release
    cyc(1'b1, wd, 1'b1, 1'b0);
    fc(wd, 0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    fc(wd, 1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    fc(wd, 2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_m_frame", {31'd0, frame_m}, 32'd0);
    chk("t5_m_cnt", {29'd0, bit_cnt_m}, 32'd0);
    chk("t5_m_pout", {28'd0, parallel_out_m}, 32'd0);
    chk("t5_l_pout", {28'd0, parallel_out_l}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    load_valid = 1'b1; parallel_in = 4'h9; en = 1'b1; shift_in = 1'b0;
    for (int i = 0; i < 4; i++) fc(4'h9, i, 1'b0, 4'h0, 1'b1, 1'b0, i == 3);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    idle_checks("t5");
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);

    chk("m_bits_left", qm.size(), 32'd0);
    chk("l_bits_left", ql.size(), 32'd0);
    chk("m_done_left", dm.size(), 32'd0);
    chk("l_done_left", dl.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
